// File: rtl/tlb_op_ctrl_pkg.sv
// Shared defines for the TLB instruction controller: CP0 field layout,
// TLB index width, op_type codes and FSM state encodings.
package tlb_op_ctrl_pkg;

  // CP0 register layout
  localparam int unsigned CP0_W          = 32;
  localparam int unsigned CP0_VPN2_LSB   = 13;
  localparam int unsigned CP0_ASID_W     = 8;
  localparam int unsigned CP0_PFN_FLAGS_W = 26;

  // TLB geometry
  localparam int unsigned TLB_IDX_W = 4;

  // op_type codes
  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACCESS  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Snapshot of the CP0 entry registers taken at accept
  typedef struct packed {
    logic [CP0_W-1:0] entryhi;
    logic [CP0_W-1:0] entrylo0;
    logic [CP0_W-1:0] entrylo1;
  } tlb_entry_t;

  // EntryHi as seen by software after TLBR: VPN2 and ASID only
  function automatic logic [CP0_W-1:0] mask_entryhi(input logic [CP0_W-1:0] hi);
    return {hi[CP0_W-1:CP0_VPN2_LSB], (CP0_VPN2_LSB - CP0_ASID_W)'(0), hi[CP0_ASID_W-1:0]};
  endfunction

  // EntryLo as seen by software after TLBR: PFN and flags only
  function automatic logic [CP0_W-1:0] mask_entrylo(input logic [CP0_W-1:0] lo);
    return {(CP0_W - CP0_PFN_FLAGS_W)'(0), lo[CP0_PFN_FLAGS_W-1:0]};
  endfunction

endpackage

// File: rtl/tlb_random_cnt.sv
// Free-running Random register for TLBWR victim selection.
// Resets to all ones and decrements every cycle, wrapping 0 -> max.
//   clk, rst : clock, async active-high reset
//   count    : current random index
module tlb_random_cnt #(
  parameter int unsigned CNT_W = tlb_op_ctrl_pkg::TLB_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '1;
    else     count <= count - CNT_W'(1);
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB instruction controller: sequences TLBP/TLBR/TLBWI/TLBWR at commit,
// drives the TLB search/read/write ports and returns CP0 results.
//   op_valid/op_type/flush : instruction at commit and pipeline kill
//   cp0_*                  : current CP0 Index/EntryHi/EntryLo0/EntryLo1
//   s_* / r_*              : TLB search and read ports (1-cycle latency)
//   tlb_we / w_*           : TLB write port
//   stall / done           : pipeline hold and completion pulse
//   res_*                  : CP0 write-back results and enables
// Macro TLB_OP_CTRL_TLBWR_EN enables the Random counter and TLBWR writes;
// without it TLBWR completes immediately without touching the TLB.
module tlb_op_ctrl #(
  parameter int unsigned TLB_IDX_W = tlb_op_ctrl_pkg::TLB_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  input  logic [1:0]           op_type,
  input  logic                 flush,
  input  logic [31:0]          cp0_index,
  input  logic [31:0]          cp0_entryhi,
  input  logic [31:0]          cp0_entrylo0,
  input  logic [31:0]          cp0_entrylo1,
  output logic [18:0]          s_vpn2,
  output logic [7:0]           s_asid,
  input  logic                 s_found,
  input  logic [TLB_IDX_W-1:0] s_index,
  output logic [TLB_IDX_W-1:0] r_index,
  input  logic [31:0]          r_entryhi,
  input  logic [31:0]          r_entrylo0,
  input  logic [31:0]          r_entrylo1,
  output logic                 tlb_we,
  output logic [TLB_IDX_W-1:0] w_index,
  output logic [31:0]          w_entryhi,
  output logic [31:0]          w_entrylo0,
  output logic [31:0]          w_entrylo1,
  output logic                 stall,
  output logic                 done,
  output logic                 res_we_index,
  output logic                 res_we_entry,
  output logic [31:0]          res_index,
  output logic [31:0]          res_entryhi,
  output logic [31:0]          res_entrylo0,
  output logic [31:0]          res_entrylo1
);
  import tlb_op_ctrl_pkg::*;

  localparam int unsigned RES_PAD_W = CP0_W - 1 - TLB_IDX_W;

  logic [2:0]           state_q, state_d;
  logic [1:0]           snap_op_q;
  logic [CP0_W-1:0]     snap_index_q;
  tlb_entry_t           snap_q;
  logic [TLB_IDX_W-1:0] wr_index_c;
  logic                 accept_c;
  logic                 done_d, tlb_we_d, res_we_index_d, res_we_entry_d;
  logic                 unused_index_hi;

  // flush wins over a new instruction
  assign accept_c = (state_q == ST_IDLE) && op_valid && !flush;

`ifdef TLB_OP_CTRL_TLBWR_EN
  logic [TLB_IDX_W-1:0] rand_cnt;

  tlb_random_cnt #(.CNT_W(TLB_IDX_W)) u_random_cnt (
    .clk   (clk),
    .rst   (rst),
    .count (rand_cnt)
  );

  assign wr_index_c = (snap_op_q == OP_TLBWR) ? rand_cnt : snap_index_q[TLB_IDX_W-1:0];
`else
  assign wr_index_c = snap_index_q[TLB_IDX_W-1:0];
`endif

  // Next state and registered-output enables
  always_comb begin
    state_d        = state_q;
    done_d         = 1'b0;
    tlb_we_d       = 1'b0;
    res_we_index_d = 1'b0;
    res_we_entry_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          case (op_type)
            OP_TLBP, OP_TLBR: state_d = ST_ACCESS;
            OP_TLBWI:         state_d = ST_WRITE;
            OP_TLBWR: begin
`ifdef TLB_OP_CTRL_TLBWR_EN
              state_d = ST_WRITE;
`else
              state_d = ST_DONE;
              done_d  = 1'b1;
`endif
            end
            default:          state_d = ST_IDLE;
          endcase
        end
      end
      ST_ACCESS: state_d = flush ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d        = ST_DONE;
          done_d         = 1'b1;
          res_we_index_d = (snap_op_q == OP_TLBP);
          res_we_entry_d = (snap_op_q == OP_TLBR);
        end
      end
      ST_WRITE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          tlb_we_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Snapshot, write port and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_op_q    <= OP_TLBP;
      snap_index_q <= '0;
      snap_q       <= '0;
      done         <= 1'b0;
      tlb_we       <= 1'b0;
      w_index      <= '0;
      res_we_index <= 1'b0;
      res_we_entry <= 1'b0;
      res_index    <= '0;
      res_entryhi  <= '0;
      res_entrylo0 <= '0;
      res_entrylo1 <= '0;
    end else begin
      done         <= done_d;
      tlb_we       <= tlb_we_d;
      res_we_index <= res_we_index_d;
      res_we_entry <= res_we_entry_d;
      if (accept_c) begin
        snap_op_q    <= op_type;
        snap_index_q <= cp0_index;
        snap_q       <= '{entryhi: cp0_entryhi, entrylo0: cp0_entrylo0, entrylo1: cp0_entrylo1};
      end
      if (tlb_we_d) w_index <= wr_index_c;
      if (res_we_index_d) res_index <= {~s_found, {RES_PAD_W{1'b0}}, s_index};
      if (res_we_entry_d) begin
        res_entryhi  <= mask_entryhi(r_entryhi);
        res_entrylo0 <= mask_entrylo(r_entrylo0);
        res_entrylo1 <= mask_entrylo(r_entrylo1);
      end
    end
  end

  // Search/read/write ports come straight from the snapshot registers
  assign s_vpn2     = snap_q.entryhi[CP0_W-1:CP0_VPN2_LSB];
  assign s_asid     = snap_q.entryhi[CP0_ASID_W-1:0];
  assign r_index    = snap_index_q[TLB_IDX_W-1:0];
  assign w_entryhi  = snap_q.entryhi;
  assign w_entrylo0 = snap_q.entrylo0;
  assign w_entrylo1 = snap_q.entrylo1;

  assign stall = accept_c || (state_q == ST_ACCESS) || (state_q == ST_CAPTURE) ||
                 (state_q == ST_WRITE);

  // Index bits above the TLB size are kept in the snapshot but never used
  assign unused_index_hi = ^snap_index_q[CP0_W-1:TLB_IDX_W];

endmodule

// File: tb/tb_tlb_op_ctrl.sv
module tb_tlb_op_ctrl;

  localparam int unsigned IDX_W = 4;
  localparam logic [1:0] OP_P  = 2'b00;
  localparam logic [1:0] OP_R  = 2'b01;
  localparam logic [1:0] OP_WI = 2'b10;
  localparam logic [1:0] OP_WR = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             op_valid = 1'b0;
  logic [1:0]       op_type = 2'b00;
  logic             flush = 1'b0;
  logic [31:0]      cp0_index = '0, cp0_entryhi = '0, cp0_entrylo0 = '0, cp0_entrylo1 = '0;
  logic [18:0]      s_vpn2;
  logic [7:0]       s_asid;
  logic             s_found = 1'b0;
  logic [IDX_W-1:0] s_index = '0;
  logic [IDX_W-1:0] r_index;
  logic [31:0]      r_entryhi = '0, r_entrylo0 = '0, r_entrylo1 = '0;
  logic             tlb_we;
  logic [IDX_W-1:0] w_index;
  logic [31:0]      w_entryhi, w_entrylo0, w_entrylo1;
  logic             stall, done, res_we_index, res_we_entry;
  logic [31:0]      res_index, res_entryhi, res_entrylo0, res_entrylo1;

  tlb_op_ctrl #(.TLB_IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type), .flush(flush),
    .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
    .r_index(r_index), .r_entryhi(r_entryhi), .r_entrylo0(r_entrylo0), .r_entrylo1(r_entrylo1),
    .tlb_we(tlb_we), .w_index(w_index), .w_entryhi(w_entryhi),
    .w_entrylo0(w_entrylo0), .w_entrylo1(w_entrylo1),
    .stall(stall), .done(done), .res_we_index(res_we_index), .res_we_entry(res_we_entry),
    .res_index(res_index), .res_entryhi(res_entryhi),
    .res_entrylo0(res_entrylo0), .res_entrylo1(res_entrylo1)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural TLB with 1-cycle search/read latency
  logic [31:0] tlb_hi [16];
  logic [31:0] tlb_lo0 [16];
  logic [31:0] tlb_lo1 [16];

  function automatic logic [IDX_W:0] lookup(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int i = 0; i < 16; i++)
      if (tlb_hi[i][31:13] == vpn2 && tlb_hi[i][7:0] == asid) return {1'b1, IDX_W'(i)};
    return '0;
  endfunction

  always @(posedge clk) begin
    {s_found, s_index} <= lookup(s_vpn2, s_asid);
    r_entryhi  <= tlb_hi[r_index];
    r_entrylo0 <= tlb_lo0[r_index];
    r_entrylo1 <= tlb_lo1[r_index];
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference state: held CP0 results and the cycle at which reset was released
  logic [31:0] m_res_index, m_res_ehi, m_res_lo0, m_res_lo1;
  int unsigned rel;

  // Random register value during a cycle: starts at 15 and loses one per clock
  function automatic logic [IDX_W-1:0] rand_at(input int unsigned wc);
    int k;
    k = int'(wc - rel);
    return IDX_W'((15 - k) & 15);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; op_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    m_res_index = '0; m_res_ehi = '0; m_res_lo0 = '0; m_res_lo1 = '0;
  endtask

  // Issue one instruction; fl_at is the cycle after accept carrying flush (-1 = none)
  task automatic run_op(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] ehi,
                        input logic [31:0] lo0, input logic [31:0] lo1, input int fl_at,
                        input bit noise, output int done_c, output logic [IDX_W-1:0] got_widx);
    int lat;
    bit killed, wr_en, exp_wr;
    int unsigned acc_cyc;
    logic [IDX_W:0] hit;
    logic [IDX_W-1:0] ri;
`ifdef TLB_OP_CTRL_TLBWR_EN
    wr_en = 1'b1;
`else
    wr_en = 1'b0;
`endif
    lat = (op == OP_P || op == OP_R) ? 3 : (op == OP_WI || wr_en) ? 2 : 1;
    killed = (fl_at >= 1) && (fl_at < lat);
    exp_wr = !killed && (op == OP_WI || (op == OP_WR && wr_en));
    done_c = -1;
    got_widx = '0;
    acc_cyc = 0;
    for (int c = 0; c <= lat + 2; c++) begin
      @(negedge clk);
      if (c == 0) begin
        op_valid = 1'b1; op_type = op; flush = 1'b0;
        cp0_index = idx; cp0_entryhi = ehi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
        acc_cyc = cyc;
      end else begin
        op_valid = (noise && c <= (killed ? fl_at : lat)) ? 1'($urandom_range(0, 1)) : 1'b0;
        op_type = 2'($urandom_range(0, 3));
        if (noise) begin
          cp0_index = $urandom(); cp0_entryhi = $urandom();
          cp0_entrylo0 = $urandom(); cp0_entrylo1 = $urandom();
        end
        flush = (c == fl_at);
      end
      #1;
      check_b("stall", stall, killed ? (c <= fl_at) : (c < lat));
      check_b("done", done, !killed && c == lat);
      check_b("tlb_we", tlb_we, exp_wr && c == lat);
      check_b("res_we_index", res_we_index, !killed && c == lat && op == OP_P);
      check_b("res_we_entry", res_we_entry, !killed && c == lat && op == OP_R);
      if (c == 1 && (op == OP_P || op == OP_R)) begin
        check("s_vpn2", 32'(s_vpn2), 32'(ehi[31:13]));
        check("s_asid", 32'(s_asid), 32'(ehi[7:0]));
        check("r_index", 32'(r_index), 32'(idx[IDX_W-1:0]));
      end
      if (done && done_c < 0) done_c = c;
      if (tlb_we) got_widx = w_index;
      if (exp_wr && c == lat) begin
        check("w_index", 32'(w_index),
              32'((op == OP_WI) ? idx[IDX_W-1:0] : rand_at(acc_cyc + 1)));
        check("w_entryhi", w_entryhi, ehi);
        check("w_entrylo0", w_entrylo0, lo0);
        check("w_entrylo1", w_entrylo1, lo1);
      end
    end
    if (!killed && op == OP_P) begin
      hit = lookup(ehi[31:13], ehi[7:0]);
      m_res_index = {~hit[IDX_W], 27'b0, hit[IDX_W-1:0]};
    end
    if (!killed && op == OP_R) begin
      ri = idx[IDX_W-1:0];
      m_res_ehi = {tlb_hi[ri][31:13], 5'b0, tlb_hi[ri][7:0]};
      m_res_lo0 = {6'b0, tlb_lo0[ri][25:0]};
      m_res_lo1 = {6'b0, tlb_lo1[ri][25:0]};
    end
    check("res_index", res_index, m_res_index);
    check("res_entryhi", res_entryhi, m_res_ehi);
    check("res_entrylo0", res_entrylo0, m_res_lo0);
    check("res_entrylo1", res_entrylo1, m_res_lo1);
    op_valid = 1'b0;
    flush = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] idx;
    logic [31:0] ehi;
    logic [31:0] lo0;
    logic [31:0] lo1;
    int          fl_at;
    int          exp_done_c;
    logic [31:0] exp_res_index;
    logic [31:0] exp_res_lo0;
    logic [3:0]  exp_widx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int dc;
    logic [IDX_W-1:0] wi;
    logic [1:0] op;
    logic [31:0] ehi;
    int fl;

    for (int i = 0; i < 16; i++) begin
      tlb_hi[i]  = {19'(32'h40000 + 32'(i) * 32'h123), 5'b0, 8'(i)};
      tlb_lo0[i] = 32'hC0000000 | (32'(i) * 32'h00111111);
      tlb_lo1[i] = 32'hF0000000 ^ (32'(i) * 32'h01020304);
    end
    tlb_hi[7]  = {19'h091A2, 5'h00, 8'h05};
    tlb_lo0[3] = 32'hFFFFFFFF;

    //            op     idx           ehi           lo0           lo1        fl  done  res_index     res_lo0       widx
    vecs[0] = '{OP_P,  32'h0,        32'h12345005, 32'h0,        32'h0,      -1, 3, 32'h00000007, 32'h00000000, 4'd0};
    vecs[1] = '{OP_P,  32'h0,        32'hABCDE0FF, 32'h0,        32'h0,      -1, 3, 32'h80000000, 32'h00000000, 4'd0};
    vecs[2] = '{OP_R,  32'h00000003, 32'h0,        32'h0,        32'h0,      -1, 3, 32'h80000000, 32'h03FFFFFF, 4'd0};
    vecs[3] = '{OP_WI, 32'h0000000A, 32'h89ABC0EE, 32'h01234567, 32'h0765432F, -1, 2, 32'h80000000, 32'h03FFFFFF, 4'd10};
    vecs[4] = '{OP_P,  32'h0,        32'h12345005, 32'h0,        32'h0,       1, -1, 32'h80000000, 32'h03FFFFFF, 4'd0};

    // Reset values
    @(negedge clk);
    #1;
    check_b("rst_stall", stall, 1'b0);
    check_b("rst_done", done, 1'b0);
    check_b("rst_tlb_we", tlb_we, 1'b0);
    check_b("rst_res_we_index", res_we_index, 1'b0);
    check_b("rst_res_we_entry", res_we_entry, 1'b0);
    check("rst_res_index", res_index, 32'h0);
    check("rst_res_entryhi", res_entryhi, 32'h0);
    check("rst_w_index", 32'(w_index), 32'h0);
    check("rst_w_entryhi", w_entryhi, 32'h0);
    check("rst_s_vpn2", 32'(s_vpn2), 32'h0);
    rst = 1'b0;
    rel = cyc;
    m_res_index = '0; m_res_ehi = '0; m_res_lo0 = '0; m_res_lo1 = '0;

    // Directed table
    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].op, vecs[v].idx, vecs[v].ehi, vecs[v].lo0, vecs[v].lo1,
             vecs[v].fl_at, 1'b0, dc, wi);
      check($sformatf("vec%0d_done_cycle", v), 32'(dc), 32'(vecs[v].exp_done_c));
      check($sformatf("vec%0d_res_index", v), res_index, vecs[v].exp_res_index);
      check($sformatf("vec%0d_res_entrylo0", v), res_entrylo0, vecs[v].exp_res_lo0);
      check($sformatf("vec%0d_w_index", v), 32'(wi), 32'(vecs[v].exp_widx));
    end

    // op_valid together with flush in IDLE: no accept
    @(negedge clk);
    op_valid = 1'b1; op_type = OP_P; cp0_entryhi = 32'h12345005; flush = 1'b1;
    #1;
    check_b("idle_flush_stall", stall, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      op_valid = 1'b0; flush = 1'b0;
      #1;
      check_b("idle_flush_stall_after", stall, 1'b0);
      check_b("idle_flush_done", done, 1'b0);
      check_b("idle_flush_res_we", res_we_index, 1'b0);
    end
    check("idle_flush_res_index", res_index, m_res_index);

    // Randomized instructions with noise on op_valid/cp0 and occasional flushes
    for (int n = 0; n < 80; n++) begin
      op = 2'($urandom_range(0, 3));
      ehi = ($urandom_range(0, 1) == 1) ? tlb_hi[$urandom_range(0, 15)] : $urandom();
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
      run_op(op, $urandom(), ehi, $urandom(), $urandom(), fl, 1'b1, dc, wi);
    end

    // TLBWR issued 20 cycles after reset release
    do_reset();
    repeat (19) @(negedge clk);
    run_op(OP_WR, 32'h00000002, 32'h5555A0AA, 32'h11111111, 32'h22222222, -1, 1'b0, dc, wi);
`ifdef TLB_OP_CTRL_TLBWR_EN
    check("tlbwr_w_index", 32'(wi), 32'd10);
    check("tlbwr_done_cycle", 32'(dc), 32'd2);
`else
    check("tlbwr_done_cycle", 32'(dc), 32'd1);
`endif

    // Reset in the middle of a TLBWI: no write may escape
    @(negedge clk);
    op_valid = 1'b1; op_type = OP_WI; cp0_index = 32'h5; cp0_entryhi = 32'hDEAD0001;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    check_b("midrst_stall_before", stall, 1'b1);
    rst = 1'b1;
    #1;
    check_b("midrst_stall", stall, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check_b("midrst_tlb_we", tlb_we, 1'b0);
      check_b("midrst_done", done, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_w_entryhi", w_entryhi, 32'h0);
    check_b("midrst_tlb_we_after", tlb_we, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLB_IDX_W, default 4, meaning TLB index width (16 entries).
REQ-002 SHALL have ports: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-003 SHALL have ports: op_valid input 1, TLB instruction at commit; op_type input 2, 00 TLBP / 01 TLBR / 10 TLBWI / 11 TLBWR; flush input 1, exception or ERET kill.
REQ-004 SHALL have inputs cp0_index, cp0_entryhi, cp0_entrylo0 and cp0_entrylo1, each 32 bits, holding the current CP0 register values.
REQ-005 SHALL have search ports: s_vpn2 output 19; s_asid output 8; s_found input 1; s_index input TLB_IDX_W.
REQ-006 SHALL have read ports: r_index output TLB_IDX_W; r_entryhi, r_entrylo0 and r_entrylo1 inputs, each 32 bits.
REQ-007 SHALL have write ports: tlb_we output 1; w_index output TLB_IDX_W; w_entryhi, w_entrylo0 and w_entrylo1 outputs, each 32 bits.
REQ-008 SHALL have pipeline outputs: stall 1; done 1.
REQ-009 SHALL have CP0 result outputs: res_we_index 1; res_we_entry 1; res_index, res_entryhi, res_entrylo0 and res_entrylo1, each 32 bits.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, CAPTURE, WRITE and DONE.
REQ-011 SHALL, in IDLE with op_valid=1 and flush=0, latch op_type and all four cp0_* values into snapshot registers.
REQ-012 SHALL, on that accept, go to ACCESS for TLBP/TLBR and to WRITE for TLBWI/TLBWR.
REQ-013 SHALL sample op_valid only in IDLE; op_valid in any other state is ignored.
REQ-014 SHALL, in ACCESS, drive s_vpn2=snap_entryhi[31:13], s_asid=snap_entryhi[7:0] and r_index=snap_index[TLB_IDX_W-1:0], then go to CAPTURE.
REQ-015 SHALL treat TLB search and read as 1-cycle latency, sampling s_found, s_index and r_* in CAPTURE.
REQ-016 SHALL, in CAPTURE for TLBP, register res_index={~s_found, 27'b0, s_index} and assert res_we_index for 1 cycle.
REQ-017 SHALL, in CAPTURE for TLBR, register res_entryhi={r_entryhi[31:13], 5'b0, r_entryhi[7:0]} and res_entrylo0/1={6'b0, r_entrylo0/1[25:0]}, and assert res_we_entry for 1 cycle.
REQ-018 SHALL, in WRITE, assert tlb_we for exactly 1 cycle with w_* equal to the snapshot values.
REQ-019 SHALL use w_index=snap_index[3:0] for TLBWI and w_index=random count for TLBWR.
REQ-020 SHALL go from CAPTURE or WRITE to DONE, pulse done=1 in DONE for 1 cycle, then return to IDLE.
REQ-021 SHALL drive stall=(IDLE & op_valid & ~flush) | ACCESS | CAPTURE | WRITE, combinationally; stall=0 in DONE.
REQ-022 SHALL give latency from accept to done of 3 cycles for TLBP/TLBR and 2 cycles for TLBWI/TLBWR.
REQ-023 SHALL, on flush in ACCESS, CAPTURE or WRITE, return to IDLE next cycle; tlb_we, res_we_*, and done SHALL all be suppressed in that cycle.
REQ-024 SHALL, on flush in DONE, still complete done (the result has already been delivered).
REQ-025 SHALL, when op_valid and flush are both high in IDLE, let flush win: no accept and stall=0.
REQ-026 SHALL hold res_* registers until the next capture; res_we_* SHALL be 0 outside CAPTURE-exit.

Reset
REQ-027 SHALL, on rst, put the FSM in IDLE; stall, done, tlb_we, res_we_* = 0; res_*, w_*, s_* and snapshots = 0; random count = 4'hF.
REQ-028 SHALL, on rst mid-operation, abort immediately with no TLB write.

Configuration
REQ-029 SHALL support macro TLB_OP_CTRL_TLBWR_EN.
REQ-030 SHALL, with TLB_OP_CTRL_TLBWR_EN defined: the random count decrements every cycle and wraps 0 to 15, and TLBWR writes at the count value sampled in WRITE.
REQ-031 SHALL, without TLB_OP_CTRL_TLBWR_EN: remove the counter; op 11 goes IDLE to DONE directly with no tlb_we and done after 1 cycle.

Structure
REQ-032 SHALL place the op_type codes, FSM state encodings and TLB_IDX_W in the shared defines header, alongside the existing CP0 defines.
REQ-033 SHALL implement the random counter as sub-module tlb_random_cnt, instantiated only under TLB_OP_CTRL_TLBWR_EN.

Verification
REQ-034 SHALL test TLBP hit: entryhi=0x12345_0_05, TLB returns found=1 and index=7 -> done at cycle 3, res_index=0x00000007, res_we_index pulses.
REQ-035 SHALL test TLBP miss: found=0 -> res_index=0x80000000.
REQ-036 SHALL test TLBR: index=3, r_entrylo0=0xFFFFFFFF -> res_entrylo0=0x03FFFFFF, res_we_entry pulses once.
REQ-037 SHALL test TLBWI: index=0x0000000A -> tlb_we single pulse with w_index=10 and w_* = snapshot, done 2 cycles after accept.
REQ-038 SHALL test a flush asserted in ACCESS -> no res_we_*, no done, FSM IDLE next cycle, stall=0.
REQ-039 SHALL test TLBWR with TLB_OP_CTRL_TLBWR_EN 20 cycles after reset -> w_index=(15-21) mod 16 = 10; without the macro -> no tlb_we, done after 1 cycle.
